// File: rtl/a2_pipe_adder.sv
// Chunked ripple-carry adder/subtractor pipeline with valid/ready flow control and a global stall.
// Optional signed saturation is compiled in when A2_PIPE_ADDER_SAT_EN is defined.
module a2_pipe_adder #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic             carry_in,
    input  logic             sub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned CW = WIDTH / STAGES;

    // Whole pipeline moves together; it only holds when the output beat is blocked.
    logic advance;
    assign advance  = out_ready || !out_valid;
    assign in_ready = advance;

    // Index k holds the inputs seen by stage k (ports for k = 0, registers of stage k-1 otherwise).
    logic             v_p [STAGES];
    logic [WIDTH-1:0] a_p [STAGES];
    logic [WIDTH-1:0] b_p [STAGES];
    logic [WIDTH-1:0] s_p [STAGES];
    logic             c_p [STAGES];

    assign v_p[0] = in_valid;
    assign a_p[0] = operand1;
    assign b_p[0] = sub ? ~operand2 : operand2;
    assign c_p[0] = sub ? ~carry_in : carry_in;
    assign s_p[0] = '0;

`ifdef A2_PIPE_ADDER_SAT_EN
    logic sat_p [STAGES];
    assign sat_p[0] = sat;
`else
    logic unused_sat;
    assign unused_sat = sat;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CW:0]      chunk;
        logic [WIDTH-1:0] s_next;

        assign chunk = {1'b0, a_p[k][k*CW +: CW]} + {1'b0, b_p[k][k*CW +: CW]}
                     + {CW'(0), c_p[k]};

        always_comb begin
            s_next              = s_p[k];
            s_next[k*CW +: CW]  = chunk[CW-1:0];
        end

        if (k < STAGES - 1) begin : g_mid
            logic             v_r;
            logic             c_r;
            logic [WIDTH-1:0] a_r;
            logic [WIDTH-1:0] b_r;
            logic [WIDTH-1:0] s_r;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    v_r <= 1'b0;
                    c_r <= 1'b0;
                    a_r <= '0;
                    b_r <= '0;
                    s_r <= '0;
                end else if (advance) begin
                    v_r <= v_p[k];
                    c_r <= chunk[CW];
                    a_r <= a_p[k];
                    b_r <= b_p[k];
                    s_r <= s_next;
                end
            end

            assign v_p[k+1] = v_r;
            assign c_p[k+1] = c_r;
            assign a_p[k+1] = a_r;
            assign b_p[k+1] = b_r;
            assign s_p[k+1] = s_r;

`ifdef A2_PIPE_ADDER_SAT_EN
            logic sat_r;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sat_r <= 1'b0;
                end else if (advance) begin
                    sat_r <= sat_p[k];
                end
            end
            assign sat_p[k+1] = sat_r;
`endif
        end else begin : g_last
            logic             raw_ovf;
            logic [WIDTH-1:0] final_sum;

            assign raw_ovf = (a_p[k][WIDTH-1] == b_p[k][WIDTH-1])
                          && (s_next[WIDTH-1] != a_p[k][WIDTH-1]);

`ifdef A2_PIPE_ADDER_SAT_EN
            // Clamp toward the sign of operand1 on signed overflow.
            assign final_sum = (sat_p[k] && raw_ovf)
                             ? (a_p[k][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                : {1'b0, {(WIDTH-1){1'b1}}})
                             : s_next;
`else
            assign final_sum = s_next;
`endif

            // Result fields only load with a valid beat, so they stay put across bubbles and stalls.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    out_valid <= 1'b0;
                    sum       <= '0;
                    carry_out <= 1'b0;
                    overflow  <= 1'b0;
                    zero      <= 1'b0;
                end else if (advance) begin
                    out_valid <= v_p[k];
                    if (v_p[k]) begin
                        sum       <= final_sum;
                        carry_out <= chunk[CW];
                        overflow  <= raw_ovf;
                        zero      <= (final_sum == '0);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_a2_pipe_adder.sv
// Directed bench for a2_pipe_adder (WIDTH=16, STAGES=2): arithmetic vectors, stall/bubble timeline, async reset.
module tb_a2_pipe_adder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] operand1;
    logic [15:0] operand2;
    logic        carry_in;
    logic        sub;
    logic        sat;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        carry_out;
    logic        overflow;
    logic        zero;

    int errors = 0;
    int checks = 0;

    a2_pipe_adder #(.WIDTH(16), .STAGES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operand1  (operand1),
        .operand2  (operand2),
        .carry_in  (carry_in),
        .sub       (sub),
        .sat       (sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

`ifdef A2_PIPE_ADDER_SAT_EN
    localparam logic [15:0] SAT_POS_SUM  = 16'h7FFF;
    localparam logic [15:0] SAT_NEG_SUM  = 16'h8000;
    localparam logic        SAT_NEG_ZERO = 1'b0;
`else
    localparam logic [15:0] SAT_POS_SUM  = 16'h8000;
    localparam logic [15:0] SAT_NEG_SUM  = 16'h0000;
    localparam logic        SAT_NEG_ZERO = 1'b1;
`endif

    // Beats used by the stall/bubble timeline, with hand-computed results.
    logic [15:0] bt_a   [6] = '{16'h0001, 16'h0010, 16'h1234, 16'hF000, 16'h0100, 16'h4000};
    logic [15:0] bt_b   [6] = '{16'h0001, 16'h0020, 16'h1111, 16'h1000, 16'h0200, 16'h4000};
    logic [15:0] bt_sum [6] = '{16'h0002, 16'h0030, 16'h2345, 16'h0000, 16'h0300, 16'h8000};
    logic        bt_co  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        bt_ov  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        bt_z   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    // Per post-edge step: drive in_valid/beat/out_ready, expect out_valid/in_ready/beat at output.
    int t_iv  [15] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 0, 1, 0, 0, 0};
    int t_idx [15] = '{0, 1, 2, 2, 2, 2, 3, 0, 0, 4, 0, 5, 0, 0, 0};
    int t_or  [15] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    int t_eov [15] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 0, 1, 0};
    int t_eir [15] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    int t_eix [15] = '{0, 0, 0, 0, 0, 0, 1, 2, 3, 0, 0, 4, 0, 5, 0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered just after a rising edge with out_ready high; checks the 2-cycle latency and result.
    task automatic send(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sb, input logic st,
                        input logic [15:0] e_sum, input logic e_co, input logic e_ov, input logic e_z);
        operand1 = a;
        operand2 = b;
        carry_in = cin;
        sub      = sb;
        sat      = st;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        #1 check({tag, "_lat1_valid"}, 32'(out_valid), 32'd0);
        @(posedge clk);
        #2;
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_sum"},   32'(sum),       32'(e_sum));
        check({tag, "_cout"},  32'(carry_out), 32'(e_co));
        check({tag, "_ovf"},   32'(overflow),  32'(e_ov));
        check({tag, "_zero"},  32'(zero),      32'(e_z));
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        operand1  = '0;
        operand2  = '0;
        carry_in  = 1'b0;
        sub       = 1'b0;
        sat       = 1'b0;

        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_sum",       32'(sum),       32'd0);
        check("rst_flags",     32'({carry_out, overflow, zero}), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk);
        #1;

        send("add_basic",  16'h000A, 16'h001A, 1'b0, 1'b0, 1'b0, 16'h0024, 1'b0, 1'b0, 1'b0);
        send("add_chunk",  16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
        send("add_wrap",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        send("sub_neg",    16'h0005, 16'h000A, 1'b0, 1'b1, 1'b0, 16'hFFFB, 1'b0, 1'b0, 1'b0);
        send("sub_zero",   16'h0005, 16'h0005, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        send("sub_borrow", 16'h0010, 16'h0001, 1'b1, 1'b1, 1'b0, 16'h000E, 1'b1, 1'b0, 1'b0);
        send("add_cin",    16'h00FF, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
        send("sat_pos",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, SAT_POS_SUM, 1'b0, 1'b1, 1'b0);
        send("sat_neg",    16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1, SAT_NEG_SUM, 1'b1, 1'b1, SAT_NEG_ZERO);
        send("nosat_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);

        // Drain the last result before the timeline.
        sat = 1'b0;
        sub = 1'b0;
        carry_in = 1'b0;
        @(posedge clk);
        #1;

        for (int t = 0; t < 15; t++) begin
            in_valid  = t_iv[t][0];
            operand1  = bt_a[t_idx[t]];
            operand2  = bt_b[t_idx[t]];
            out_ready = t_or[t][0];
            #1;
            check($sformatf("tl%0d_out_valid", t), 32'(out_valid), 32'(t_eov[t]));
            check($sformatf("tl%0d_in_ready", t),  32'(in_ready),  32'(t_eir[t]));
            if (t_eov[t] == 1) begin
                check($sformatf("tl%0d_sum", t),  32'(sum),       32'(bt_sum[t_eix[t]]));
                check($sformatf("tl%0d_cout", t), 32'(carry_out), 32'(bt_co[t_eix[t]]));
                check($sformatf("tl%0d_ovf", t),  32'(overflow),  32'(bt_ov[t_eix[t]]));
                check($sformatf("tl%0d_zero", t), 32'(zero),      32'(bt_z[t_eix[t]]));
            end
            @(posedge clk);
            #1;
        end

        // Two beats in flight, then reset between edges.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        operand1  = bt_a[2];
        operand2  = bt_b[2];
        @(posedge clk);
        #1;
        operand1 = bt_a[1];
        operand2 = bt_b[1];
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        check("pre_rst_sum",   32'(sum),       32'h2345);
        #2 reset = 1'b1;
        #1;
        check("async_rst_valid",    32'(out_valid), 32'd0);
        check("async_rst_sum",      32'(sum),       32'd0);
        check("async_rst_in_ready", 32'(in_ready),  32'd1);
        @(posedge clk);
        #1 check("rst_held_valid", 32'(out_valid), 32'd0);
        #3 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 check($sformatf("post_rst_stale%0d", i), 32'(out_valid), 32'd0);
        end
        send("post_rst", 16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
